// File: rtl/bcd_time_keeper.sv
// BCD HH:MM:SS real-time clock with set mode and validated parallel load.
// Drives a 24-bit packed BCD time bus that is always a legal time of day.
module bcd_time_keeper #(
  parameter int TICK_DIV = 50000000,
  parameter int HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        set_mode,
  input  logic        inc_pulse,
  input  logic [1:0]  inc_sel,
  input  logic        load_valid,
  input  logic [23:0] load_data,
  output logic [23:0] time_data,
  output logic        sec_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] H_LAST =
    {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  typedef enum logic {S_RUN, S_SET} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_in_set;
  logic [PW-1:0]   r_presc;
  logic [23:0]     r_time;
  logic            r_sec;
  logic            r_day;
  logic            r_err;
  logic [8:0]      w_s;
  logic [8:0]      w_m;
  logic [8:0]      w_h;
  logic            w_carry_m;
  logic            w_day;
  logic            w_tick;
  logic            w_load_ok;
  logic [23:0]     w_tick_time;
  logic [23:0]     w_inc_time;

  // {wrap, next} for a 00..59 BCD field
  function automatic logic [8:0] f_inc60(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {1'b0, v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return 9'h100;
  endfunction

  function automatic logic [8:0] f_inc_hr(input logic [7:0] v);
    if (v == H_LAST) return 9'h100;
    if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_set    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_in_set = set_mode;
        if (set_mode) w_state_nxt = S_SET;
      end
      S_SET: begin
        w_in_set = set_mode;
        if (!set_mode) w_state_nxt = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_s       = f_inc60(r_time[7:0]);
    w_m       = f_inc60(r_time[15:8]);
    w_h       = f_inc_hr(r_time[23:16]);
    w_carry_m = w_s[8] & w_m[8];
    w_day     = w_carry_m & w_h[8];
    w_tick_time = {
      w_carry_m ? w_h[7:0] : r_time[23:16],
      w_s[8]    ? w_m[7:0] : r_time[15:8],
      w_s[7:0]
    };
    w_tick = !w_in_set && run_en && (r_presc == P_LAST);
  end

  // set-mode increments never carry into the next field
  always_comb begin
    w_inc_time = r_time;
    case (inc_sel)
      2'd0:    w_inc_time[7:0]   = w_s[7:0];
      2'd1:    w_inc_time[15:8]  = w_m[7:0];
      2'd2:    w_inc_time[23:16] = w_h[7:0];
      default: w_inc_time = r_time;
    endcase
  end

  always_comb begin
    w_load_ok =
      (load_data[3:0]   <= 4'd9) &&
      (load_data[7:4]   <= 4'd5) &&
      (load_data[11:8]  <= 4'd9) &&
      (load_data[15:12] <= 4'd5) &&
      (load_data[19:16] <= 4'd9) &&
      (load_data[23:20] <= 4'd2) &&
      !((load_data[23:20] == 4'd2) &&
        (load_data[19:16] > 4'd3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time  <= '0;
      r_presc <= '0;
      r_sec   <= 1'b0;
      r_day   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sec <= 1'b0;
      r_day <= 1'b0;
      r_err <= 1'b0;
      if (load_valid && w_load_ok) begin
        r_time  <= load_data;
        r_presc <= '0;
      end else begin
        r_err <= load_valid;
        if (w_in_set) begin
          r_presc <= '0;
          if (inc_pulse) r_time <= w_inc_time;
        end else if (w_tick) begin
          r_presc <= '0;
          r_time  <= w_tick_time;
          r_sec   <= 1'b1;
          r_day   <= w_day;
        end else if (run_en) begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign time_data = r_time;
  assign sec_pulse = r_sec;
  assign day_pulse = r_day;
  assign load_err  = r_err;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Scoreboard bench for bcd_time_keeper with a 4-cycle tick.
// Expected {time, sec, day, err} per cycle are queued at drive time.
module tb_bcd_time_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        set_mode;
  logic        inc_pulse;
  logic [1:0]  inc_sel;
  logic        load_valid;
  logic [23:0] load_data;
  logic [23:0] time_data;
  logic        sec_pulse;
  logic        day_pulse;
  logic        load_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [26:0] q_exp[$];
  string       q_tag[$];
  logic [26:0] r_e;
  string       r_tg;

  bcd_time_keeper #(.TICK_DIV(4), .HOUR_MAX(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .set_mode   (set_mode),
    .inc_pulse  (inc_pulse),
    .inc_sel    (inc_sel),
    .load_valid (load_valid),
    .load_data  (load_data),
    .time_data  (time_data),
    .sec_pulse  (sec_pulse),
    .day_pulse  (day_pulse),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // expectation for the next rising edge; strobes last one cycle
  task automatic step(input logic [23:0] t, input logic s,
                      input logic d, input logic e,
                      input string tag);
    q_exp.push_back({t, s, d, e});
    q_tag.push_back(tag);
    @(negedge clk);
    load_valid = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (q_exp.size() > 0) begin
      r_e  = q_exp.pop_front();
      r_tg = q_tag.pop_front();
      chk(r_tg, {5'd0, time_data, sec_pulse, day_pulse, load_err},
          {5'd0, r_e});
    end
  end

  initial begin
    logic [23:0] h_exp;
    int h;
    rst_n = 1'b0; run_en = 1'b0; set_mode = 1'b0;
    inc_pulse = 1'b0; inc_sel = 2'd0;
    load_valid = 1'b0; load_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_time", {8'd0, time_data}, 32'h0);
    chk("rst_pulses", {29'd0, sec_pulse, day_pulse, load_err}, 32'h0);

    // first ticks after reset
    rst_n = 1'b1; run_en = 1'b1;
    repeat (3) step(24'h000000, 0, 0, 0, "pre_t1");
    step(24'h000001, 1, 0, 0, "tick1");
    repeat (3) step(24'h000001, 0, 0, 0, "pre_t2");
    step(24'h000002, 1, 0, 0, "tick2");

    // day rollover
    load_valid = 1'b1; load_data = 24'h235958;
    step(24'h235958, 0, 0, 0, "load_2359");
    repeat (3) step(24'h235958, 0, 0, 0, "hold_58");
    step(24'h235959, 1, 0, 0, "tick_59");
    repeat (3) step(24'h235959, 0, 0, 0, "hold_59");
    step(24'h000000, 1, 1, 0, "day_roll");

    // rejected loads; last one coincides with a tick
    load_valid = 1'b1; load_data = 24'h096000;
    step(24'h000000, 0, 0, 1, "bad_min");
    step(24'h000000, 0, 0, 0, "err_clr");
    load_valid = 1'b1; load_data = 24'h240000;
    step(24'h000000, 0, 0, 1, "bad_hr");
    load_valid = 1'b1; load_data = 24'h00000A;
    step(24'h000001, 1, 0, 1, "bad_sec_tick");

    // set mode increments
    set_mode = 1'b1;
    load_valid = 1'b1; load_data = 24'h125959;
    step(24'h125959, 0, 0, 0, "set_load");
    inc_pulse = 1'b1; inc_sel = 2'd0;
    step(24'h125900, 0, 0, 0, "inc_sec");
    inc_pulse = 1'b1; inc_sel = 2'd1;
    step(24'h120000, 0, 0, 0, "inc_min");
    for (int k = 0; k < 12; k++) begin
      h = (13 + k) % 24;
      h_exp = {4'(h / 10), 4'(h % 10), 16'h0000};
      inc_pulse = 1'b1; inc_sel = 2'd2;
      step(h_exp, 0, 0, 0, "inc_hr");
    end
    inc_pulse = 1'b1; inc_sel = 2'd3;
    step(24'h000000, 0, 0, 0, "inc_none");
    repeat (80) step(24'h000000, 0, 0, 0, "set_hold");

    // leave set mode; inc in run is ignored
    set_mode = 1'b0;
    inc_pulse = 1'b1; inc_sel = 2'd2;
    step(24'h000000, 0, 0, 0, "run_inc_ign");
    repeat (2) step(24'h000000, 0, 0, 0, "exit_wait");
    step(24'h000001, 1, 0, 0, "exit_tick");

    // load beats inc and tick at terminal count
    repeat (3) step(24'h000001, 0, 0, 0, "pre_tc");
    load_valid = 1'b1; load_data = 24'h101010;
    inc_pulse = 1'b1; inc_sel = 2'd0;
    step(24'h101010, 0, 0, 0, "load_vs_tick");
    repeat (3) step(24'h101010, 0, 0, 0, "post_load");
    step(24'h101011, 1, 0, 0, "post_load_tick");

    // run_en freeze at prescaler 2
    repeat (2) step(24'h101011, 0, 0, 0, "to_p2");
    run_en = 1'b0;
    repeat (10) step(24'h101011, 0, 0, 0, "frozen");
    run_en = 1'b1;
    step(24'h101011, 0, 0, 0, "resume");
    step(24'h101012, 1, 0, 0, "resume_tick");

    // hour units carry into tens
    load_valid = 1'b1; load_data = 24'h095959;
    step(24'h095959, 0, 0, 0, "load_0959");
    repeat (3) step(24'h095959, 0, 0, 0, "hold_0959");
    step(24'h100000, 1, 0, 0, "hr_carry");

    // asynchronous reset mid-count
    repeat (2) step(24'h100000, 0, 0, 0, "pre_rst");
    rst_n = 1'b0;
    #1;
    chk("async_rst_time", {8'd0, time_data}, 32'h0);
    chk("async_rst_pls", {29'd0, sec_pulse, day_pulse, load_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(24'h000000, 0, 0, 0, "post_rst");
    step(24'h000001, 1, 0, 0, "post_rst_tick");

    chk("drain", q_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
